// File: rtl/gesture_recog_ctrl.sv
// Frame sequencer for the gesture classifier: holds features across the classifier pipeline,
// captures the result at a fixed cycle and debounces it over consecutive frames.
module gesture_recog_ctrl #(
   parameter int unsigned PIPE_LAT   = 6,
   parameter int unsigned STABLE_CNT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        feat_valid,
   input  logic [31:0] hu_1_in,
   input  logic [31:0] hu_2_in,
   input  logic [23:0] pa_in,
   output logic [31:0] clf_hu_1,
   output logic [31:0] clf_hu_2,
   output logic [23:0] clf_pa,
   input  logic [5:0]  clf_code,
   output logic        busy,
   output logic [5:0]  raw_code,
   output logic        raw_valid,
   output logic [5:0]  gesture,
   output logic        gesture_valid,
   output logic [7:0]  drop_cnt
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StVote = 2'd2;

   localparam logic [3:0] WaitLast   = 4'(PIPE_LAT);
   localparam logic [3:0] StableMax  = 4'(STABLE_CNT);
   localparam logic [5:0] CodeNoHand = 6'd8;
   localparam logic [5:0] CodeMaxGes = 6'd5;

   logic [1:0]  state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] hu_1_q, hu_1_d;
   logic [31:0] hu_2_q, hu_2_d;
   logic [23:0] pa_q, pa_d;
   logic [5:0]  raw_code_q, raw_code_d;
   logic        raw_valid_q, raw_valid_d;
   logic [5:0]  gesture_q, gesture_d;
   logic        gesture_valid_q, gesture_valid_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;
   logic [5:0]  cand_q, cand_d;
   logic [3:0]  match_cnt_q, match_cnt_d;

   logic        code_ok;
   logic [5:0]  vote_cand;
   logic [3:0]  vote_match;
   logic        vote_commit;

   // Only gestures 0..5 and "no hand" take part in debouncing; everything else resets the run.
   assign code_ok = (raw_code_q <= CodeMaxGes) || (raw_code_q == CodeNoHand);

   always_comb begin
      vote_cand  = cand_q;
      vote_match = match_cnt_q;
      if (!code_ok) begin
         vote_match = 4'd0;
      end else if ((raw_code_q == cand_q) && (match_cnt_q != 4'd0)) begin
         vote_match = (match_cnt_q >= StableMax) ? StableMax : match_cnt_q + 4'd1;
      end else begin
         vote_cand  = raw_code_q;
         vote_match = 4'd1;
      end
      vote_commit = code_ok && (vote_match == StableMax) && (vote_cand != gesture_q);
   end

   always_comb begin
      state_d         = state_q;
      wait_cnt_d      = wait_cnt_q;
      hu_1_d          = hu_1_q;
      hu_2_d          = hu_2_q;
      pa_d            = pa_q;
      raw_code_d      = raw_code_q;
      raw_valid_d     = 1'b0;
      gesture_d       = gesture_q;
      gesture_valid_d = 1'b0;
      drop_cnt_d      = drop_cnt_q;
      cand_d          = cand_q;
      match_cnt_d     = match_cnt_q;

      if (feat_valid && (state_q != StIdle) && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end

      case (state_q)
         StIdle: begin
            if (feat_valid) begin
               hu_1_d     = hu_1_in;
               hu_2_d     = hu_2_in;
               pa_d       = pa_in;
               wait_cnt_d = 4'd0;
               state_d    = StWait;
            end
         end
         StWait: begin
            wait_cnt_d = wait_cnt_q + 4'd1;
            if (wait_cnt_q == WaitLast) begin
               raw_code_d  = clf_code;
               raw_valid_d = 1'b1;
               state_d     = StVote;
            end
         end
         StVote: begin
            cand_d      = vote_cand;
            match_cnt_d = vote_match;
            if (vote_commit) begin
               gesture_d       = vote_cand;
               gesture_valid_d = 1'b1;
            end
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         wait_cnt_q      <= 4'd0;
         hu_1_q          <= 32'd0;
         hu_2_q          <= 32'd0;
         pa_q            <= 24'd0;
         raw_code_q      <= 6'd0;
         raw_valid_q     <= 1'b0;
         gesture_q       <= CodeNoHand;
         gesture_valid_q <= 1'b0;
         drop_cnt_q      <= 8'd0;
         cand_q          <= 6'd0;
         match_cnt_q     <= 4'd0;
      end else begin
         state_q         <= state_d;
         wait_cnt_q      <= wait_cnt_d;
         hu_1_q          <= hu_1_d;
         hu_2_q          <= hu_2_d;
         pa_q            <= pa_d;
         raw_code_q      <= raw_code_d;
         raw_valid_q     <= raw_valid_d;
         gesture_q       <= gesture_d;
         gesture_valid_q <= gesture_valid_d;
         drop_cnt_q      <= drop_cnt_d;
         cand_q          <= cand_d;
         match_cnt_q     <= match_cnt_d;
      end
   end

   assign busy          = (state_q != StIdle);
   assign clf_hu_1      = hu_1_q;
   assign clf_hu_2      = hu_2_q;
   assign clf_pa        = pa_q;
   assign raw_code      = raw_code_q;
   assign raw_valid     = raw_valid_q;
   assign gesture       = gesture_q;
   assign gesture_valid = gesture_valid_q;
   assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_gesture_recog_ctrl.sv
// Bench for gesture_recog_ctrl: a 6-stage classifier model, a table of frames with
// expected debounce results, and a pulse scoreboard checked at the falling edge.
module tb_gesture_recog_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        feat_valid = 1'b0;
   logic [31:0] hu_1_in = '0;
   logic [31:0] hu_2_in = '0;
   logic [23:0] pa_in = '0;
   logic [31:0] clf_hu_1;
   logic [31:0] clf_hu_2;
   logic [23:0] clf_pa;
   logic [5:0]  clf_code;
   logic        busy;
   logic [5:0]  raw_code;
   logic        raw_valid;
   logic [5:0]  gesture;
   logic        gesture_valid;
   logic [7:0]  drop_cnt;

   gesture_recog_ctrl #(.PIPE_LAT(6), .STABLE_CNT(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .feat_valid    (feat_valid),
      .hu_1_in       (hu_1_in),
      .hu_2_in       (hu_2_in),
      .pa_in         (pa_in),
      .clf_hu_1      (clf_hu_1),
      .clf_hu_2      (clf_hu_2),
      .clf_pa        (clf_pa),
      .clf_code      (clf_code),
      .busy          (busy),
      .raw_code      (raw_code),
      .raw_valid     (raw_valid),
      .gesture       (gesture),
      .gesture_valid (gesture_valid),
      .drop_cnt      (drop_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Classifier model: code = hu_1[5:0] ^ 25, available six edges after clf_* change.
   logic [5:0] pipe [6];
   initial for (int i = 0; i < 6; i++) pipe[i] = 6'd0;
   always @(posedge clk) begin
      pipe[0] <= clf_hu_1[5:0] ^ 6'd25;
      for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
   end
   assign clf_code = pipe[5];

   function automatic logic [31:0] hu_for(input logic [5:0] code, input logic [25:0] salt);
      return {salt, code ^ 6'd25};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [5:0] code;
      int         at;
   } ev_t;
   ev_t rawq[$];
   ev_t gq[$];
   logic mon_en = 1'b1;
   logic rv_prev = 1'b0;
   logic gv_prev = 1'b0;

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (raw_valid) begin
            chk("raw_pulse_width", 32'(rv_prev), 32'd0);
            if (rawq.size() == 0) begin
               chk("raw_unexpected", 32'(raw_valid), 32'd0);
            end else begin
               ev_t e;
               e = rawq.pop_front();
               chk("raw_code", 32'(raw_code), 32'(e.code));
               chk("raw_cycle", 32'(cyc), 32'(e.at));
            end
         end
         if (gesture_valid) begin
            chk("gv_pulse_width", 32'(gv_prev), 32'd0);
            if (gq.size() == 0) begin
               chk("gv_unexpected", 32'(gesture_valid), 32'd0);
            end else begin
               ev_t e;
               e = gq.pop_front();
               chk("gv_gesture", 32'(gesture), 32'(e.code));
               chk("gv_cycle", 32'(cyc), 32'(e.at));
            end
         end
      end
      rv_prev <= raw_valid;
      gv_prev <= gesture_valid;
   end

   task automatic check_reset_state(input string tag);
      chk({tag, "_gesture"}, 32'(gesture), 32'd8);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
      chk({tag, "_raw"}, 32'(raw_code), 32'd0);
      chk({tag, "_pulses"}, 32'({raw_valid, gesture_valid}), 32'd0);
      chk({tag, "_clf"}, clf_hu_1 | clf_hu_2 | 32'(clf_pa), 32'd0);
   endtask

   // Called at a falling edge; leaves rst_n released, also at a falling edge.
   task automatic do_reset();
      rst_n = 1'b0;
      feat_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rawq.delete();
      gq.delete();
      check_reset_state("reset");
   endtask

   // Called at a falling edge; returns at the falling edge after edge 8 of the frame.
   task automatic run_frame(input logic [31:0] h1, input logic [31:0] h2, input logic [23:0] pa,
                            input logic [5:0] exp_raw, input logic exp_gv,
                            input logic [5:0] exp_g);
      int  n0;
      logic held_ok;
      logic busy_ok;
      ev_t e;
      feat_valid = 1'b1;
      hu_1_in = h1;
      hu_2_in = h2;
      pa_in = pa;
      @(negedge clk);
      feat_valid = 1'b0;
      hu_1_in = ~h1;
      hu_2_in = ~h2;
      pa_in = ~pa;
      n0 = cyc;
      e.code = exp_raw;
      e.at = n0 + 7;
      rawq.push_back(e);
      if (exp_gv) begin
         e.code = exp_g;
         e.at = n0 + 8;
         gq.push_back(e);
      end
      held_ok = 1'b1;
      busy_ok = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i != 0) @(negedge clk);
         if (clf_hu_1 !== h1 || clf_hu_2 !== h2 || clf_pa !== pa) held_ok = 1'b0;
         if (busy !== (i < 8)) busy_ok = 1'b0;
      end
      chk("clf_held", 32'(held_ok), 32'd1);
      chk("busy_seq", 32'(busy_ok), 32'd1);
      chk("gesture_after", 32'(gesture), 32'(exp_g));
      chk("raw_after", 32'(raw_code), 32'(exp_raw));
   endtask

   typedef struct {
      logic        rst;
      logic [5:0]  code;
      logic [31:0] hu2;
      logic [23:0] pa;
      logic        exp_gv;
      logic [5:0]  exp_g;
   } vec_t;
   vec_t vecs[22];

   initial begin
      vecs[0]  = '{1'b0, 6'd0,  32'd401, 24'd172, 1'b0, 6'd8};
      vecs[1]  = '{1'b0, 6'd2,  32'd11,  24'd3,   1'b0, 6'd8};
      vecs[2]  = '{1'b0, 6'd2,  32'd12,  24'd4,   1'b0, 6'd8};
      vecs[3]  = '{1'b0, 6'd2,  32'd13,  24'd5,   1'b1, 6'd2};
      vecs[4]  = '{1'b0, 6'd2,  32'd14,  24'd6,   1'b0, 6'd2};
      vecs[5]  = '{1'b1, 6'd2,  32'd21,  24'd7,   1'b0, 6'd8};
      vecs[6]  = '{1'b0, 6'd2,  32'd22,  24'd8,   1'b0, 6'd8};
      vecs[7]  = '{1'b0, 6'd7,  32'd23,  24'd9,   1'b0, 6'd8};
      vecs[8]  = '{1'b0, 6'd2,  32'd24,  24'd10,  1'b0, 6'd8};
      vecs[9]  = '{1'b0, 6'd2,  32'd25,  24'd11,  1'b0, 6'd8};
      vecs[10] = '{1'b0, 6'd2,  32'd26,  24'd12,  1'b1, 6'd2};
      vecs[11] = '{1'b0, 6'd5,  32'd31,  24'd13,  1'b0, 6'd2};
      vecs[12] = '{1'b0, 6'd5,  32'd32,  24'd14,  1'b0, 6'd2};
      vecs[13] = '{1'b0, 6'd5,  32'd33,  24'd15,  1'b1, 6'd5};
      vecs[14] = '{1'b0, 6'd8,  32'd41,  24'd16,  1'b0, 6'd5};
      vecs[15] = '{1'b0, 6'd40, 32'd42,  24'd17,  1'b0, 6'd5};
      vecs[16] = '{1'b0, 6'd8,  32'd43,  24'd18,  1'b0, 6'd5};
      vecs[17] = '{1'b0, 6'd8,  32'd44,  24'd19,  1'b0, 6'd5};
      vecs[18] = '{1'b0, 6'd6,  32'd45,  24'd20,  1'b0, 6'd5};
      vecs[19] = '{1'b0, 6'd8,  32'd46,  24'd21,  1'b0, 6'd5};
      vecs[20] = '{1'b0, 6'd8,  32'd47,  24'd22,  1'b0, 6'd5};
      vecs[21] = '{1'b0, 6'd8,  32'd48,  24'd23,  1'b1, 6'd8};
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic quiet;
      int   n0;
      ev_t  e;
      @(negedge clk);
      do_reset();

      // Idle after reset: nothing moves.
      quiet = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (gesture !== 6'd8 || raw_valid || gesture_valid || busy || drop_cnt !== 8'd0 ||
             clf_hu_1 !== 32'd0 || clf_hu_2 !== 32'd0 || clf_pa !== 24'd0) quiet = 1'b0;
      end
      chk("idle_quiet", 32'(quiet), 32'd1);

      // Table of frames, back to back at the maximum rate.
      for (int i = 0; i < 22; i++) begin
         if (vecs[i].rst) do_reset();
         run_frame(hu_for(vecs[i].code, 26'(i)), vecs[i].hu2, vecs[i].pa,
                   vecs[i].code, vecs[i].exp_gv, vecs[i].exp_g);
      end
      repeat (2) @(negedge clk);
      chk("table_raw_left", 32'(rawq.size()), 32'd0);
      chk("table_gv_left", 32'(gq.size()), 32'd0);

      // feat_valid at edges 0, 3 and 8: only the first frame is taken.
      feat_valid = 1'b1;
      hu_1_in = hu_for(6'd7, 26'd99);
      @(negedge clk);
      feat_valid = 1'b0;
      n0 = cyc;
      e.code = 6'd7;
      e.at = n0 + 7;
      rawq.push_back(e);
      repeat (2) @(negedge clk);
      feat_valid = 1'b1;
      hu_1_in = hu_for(6'd1, 26'd98);
      @(negedge clk);
      feat_valid = 1'b0;
      chk("clf_after_drop", clf_hu_1, hu_for(6'd7, 26'd99));
      repeat (4) @(negedge clk);
      feat_valid = 1'b1;
      @(negedge clk);
      feat_valid = 1'b0;
      chk("drop_cnt_2", 32'(drop_cnt), 32'd2);
      chk("busy_after_vote", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("drop_raw_left", 32'(rawq.size()), 32'd0);
      chk("drop_busy_idle", 32'(busy), 32'd0);

      // Continuous feat_valid: 38 frames accepted, 8 drops each, counter must saturate.
      mon_en = 1'b0;
      feat_valid = 1'b1;
      hu_1_in = hu_for(6'd7, 26'd97);
      repeat (9 * 38) @(negedge clk);
      feat_valid = 1'b0;
      repeat (12) @(negedge clk);
      chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
      mon_en = 1'b1;

      // Reset in the middle of a frame.
      do_reset();
      feat_valid = 1'b1;
      hu_1_in = hu_for(6'd3, 26'd5);
      hu_2_in = 32'd77;
      pa_in = 24'd66;
      @(negedge clk);
      feat_valid = 1'b0;
      chk("abort_latched", clf_hu_1, hu_for(6'd3, 26'd5));
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_state("abort");
      @(negedge clk);
      run_frame(hu_for(6'd5, 26'd6), 32'd123, 24'd45, 6'd5, 1'b0, 6'd8);
      repeat (12) @(negedge clk);
      chk("abort_raw_left", 32'(rawq.size()), 32'd0);
      chk("abort_gv_left", 32'(gq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
